uart_tx_arbiter: RTL and testbench

Shares the single FPGA→PC `uart_tx` transmitter among three byte sources in the whack-a-mole top level:
- channel 0: game-over code `"R"`;
- channel 1: mole-position report `"0"`..`"4"`;
- channel 2: debug echo of received bytes.

Each channel has a one-deep holding register. A fixed-priority FSM issues one byte at a time to `uart_tx` through its `tx_start`/`tx_busy` handshake. This replaces the ad-hoc per-feature transmit logic in the top layer.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Byte-source / uart_tx side signals of the transmit arbiter.
// master: the driver of requests and tx_busy; slave: the arbiter itself.
interface uart_tx_arbiter_if;
  logic [2:0] req;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [7:0] req_data2;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [2:0] grant;
  logic [2:0] pending;
  logic [2:0] drop;
  logic       timeout;

  modport master (
    output req, req_data0, req_data1, req_data2, tx_busy,
    input  tx_start, tx_data, grant, pending, drop, timeout
  );

  modport slave (
    input  req, req_data0, req_data1, req_data2, tx_busy,
    output tx_start, tx_data, grant, pending, drop, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among three byte sources: per-channel one-deep holding
// registers feed a fixed-priority (0 > 1 > 2) issue FSM that hands one byte
// at a time to uart_tx over its tx_start/tx_busy handshake.

// One channel's holding register. A new request always wins over the
// issue-side clear, so a byte arriving on its own grant edge stays pending.
module uart_tx_arbiter_chan (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic [7:0] data,
  input  logic       take,
  output logic       pending,
  output logic [7:0] hold,
  output logic       drop
);
  // capture, latest-wins overwrite with drop report, clear on issue
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      hold    <= '0;
      drop    <= 1'b0;
    end else begin
      drop <= req && pending && !take;
      if (req) begin
        hold    <= data;
        pending <= 1'b1;
      end else if (take) begin
        pending <= 1'b0;
      end
    end
  end
endmodule

module uart_tx_arbiter #(
  parameter int BUSY_WAIT_MAX = 16
) (
  input logic              clock,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int NUM_CH = 3;
  localparam logic [7:0] CNT_LAST = 8'(BUSY_WAIT_MAX - 1);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

  logic [NUM_CH-1:0][7:0] req_data;
  logic [NUM_CH-1:0][7:0] hold;
  logic [NUM_CH-1:0]      pend;
  logic [NUM_CH-1:0]      drop;
  logic [NUM_CH-1:0]      take;
  logic [NUM_CH-1:0]      sel_oh;
  logic [1:0]             sel_idx;

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic              start_q, start_nxt;
  logic [NUM_CH-1:0] grant_q, grant_nxt;
  logic [7:0]        data_q, data_nxt;
  logic              tmo_q, tmo_nxt;

  assign req_data = {bus.req_data2, bus.req_data1, bus.req_data0};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    uart_tx_arbiter_chan u_chan (
      .clock   (clock),
      .reset   (reset),
      .req     (bus.req[g]),
      .data    (req_data[g]),
      .take    (take[g]),
      .pending (pend[g]),
      .hold    (hold[g]),
      .drop    (drop[g])
    );
  end

  // lowest-index pending channel wins
  always_comb begin
    sel_idx = '0;
    sel_oh  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_idx    = 2'(i);
        sel_oh     = '0;
        sel_oh[i]  = 1'b1;
      end
    end
  end

  // issue FSM: next state, wait counter and registered output values
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start_nxt = 1'b0;
    grant_nxt = '0;
    data_nxt  = data_q;
    tmo_nxt   = 1'b0;
    take      = '0;
    case (state)
      IDLE: begin
        if ((|pend) && !bus.tx_busy) begin
          take      = sel_oh;
          start_nxt = 1'b1;
          grant_nxt = sel_oh;
          data_nxt  = hold[sel_idx];
          cnt_nxt   = '0;
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        if (bus.tx_busy) begin
          state_nxt = WAIT_LO;
        end else if (cnt >= CNT_LAST) begin
          // uart_tx never acknowledged; the byte is abandoned
          tmo_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_LO: begin
        if (!bus.tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      start_q <= 1'b0;
      grant_q <= '0;
      data_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      start_q <= start_nxt;
      grant_q <= grant_nxt;
      data_q  <= data_nxt;
      tmo_q   <= tmo_nxt;
    end
  end

  assign bus.tx_start = start_q;
  assign bus.tx_data  = data_q;
  assign bus.grant    = grant_q;
  assign bus.pending  = pend;
  assign bus.drop     = drop;
  assign bus.timeout  = tmo_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart_tx busy model.
module tb_uart_tx_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic model_en = 1'b0;
  logic force_busy = 1'b0;
  logic model_busy;
  int   busy_cnt;
  int   n_checks = 0;
  int   n_err = 0;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.BUSY_WAIT_MAX(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  assign bus.tx_busy = model_busy | force_busy;

  // uart_tx model: busy for 20 cycles starting the cycle after tx_start
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      model_busy <= 1'b0;
      busy_cnt   <= 0;
    end else if (model_en && bus.tx_start) begin
      model_busy <= 1'b1;
      busy_cnt   <= 20;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) model_busy <= 1'b0;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // next issue lands 2 cycles after tx_busy falls (23 cycles after the last start)
  task automatic next_issue(input string tag, input logic [7:0] d, input logic [2:0] g);
    cyc(22);
    chk({tag, "_gap"}, 32'(bus.tx_start), 32'd0);
    cyc();
    chk({tag, "_start"}, 32'(bus.tx_start), 32'd1);
    chk({tag, "_data"}, 32'(bus.tx_data), 32'(d));
    chk({tag, "_grant"}, 32'(bus.grant), 32'(g));
  endtask

  task automatic pulse_req(input logic [2:0] r, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2);
    bus.req = r;
    bus.req_data0 = d0;
    bus.req_data1 = d1;
    bus.req_data2 = d2;
  endtask

  initial begin
    bit seen;
    pulse_req(3'b000, 8'h00, 8'h00, 8'h00);

    // reset state
    cyc(2);
    chk("rst_start", 32'(bus.tx_start), 32'd0);
    chk("rst_data", 32'(bus.tx_data), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_pend", 32'(bus.pending), 32'd0);
    chk("rst_drop", 32'(bus.drop), 32'd0);
    chk("rst_tmo", 32'(bus.timeout), 32'd0);
    reset = 1'b1;
    model_en = 1'b1;
    cyc(2);

    // single request, 2-cycle latency
    pulse_req(3'b010, 8'h00, 8'h32, 8'h00);
    cyc();
    bus.req = 3'b000;
    chk("single_pend", 32'(bus.pending), 32'b010);
    chk("single_early", 32'(bus.tx_start), 32'd0);
    cyc();
    chk("single_start", 32'(bus.tx_start), 32'd1);
    chk("single_data", 32'(bus.tx_data), 32'h32);
    chk("single_grant", 32'(bus.grant), 32'b010);
    chk("single_pend0", 32'(bus.pending), 32'd0);
    cyc();
    chk("single_width", 32'(bus.tx_start), 32'd0);
    chk("single_hold", 32'(bus.tx_data), 32'h32);
    cyc(25);

    // priority R > 3 > X
    pulse_req(3'b111, 8'h52, 8'h33, 8'h58);
    cyc();
    bus.req = 3'b000;
    chk("prio_pend", 32'(bus.pending), 32'b111);
    cyc();
    chk("prio_R_start", 32'(bus.tx_start), 32'd1);
    chk("prio_R_data", 32'(bus.tx_data), 32'h52);
    chk("prio_R_grant", 32'(bus.grant), 32'b001);
    chk("prio_R_pend", 32'(bus.pending), 32'b110);
    next_issue("prio_3", 8'h33, 3'b010);
    next_issue("prio_X", 8'h58, 3'b100);
    chk("prio_pend0", 32'(bus.pending), 32'd0);
    cyc(25);

    // overwrite while busy
    force_busy = 1'b1;
    pulse_req(3'b100, 8'h00, 8'h00, 8'h41);
    cyc();
    chk("ovw_pend", 32'(bus.pending), 32'b100);
    pulse_req(3'b100, 8'h00, 8'h00, 8'h42);
    cyc();
    bus.req = 3'b000;
    chk("ovw_drop", 32'(bus.drop), 32'b100);
    chk("ovw_nostart", 32'(bus.tx_start), 32'd0);
    cyc();
    chk("ovw_drop_once", 32'(bus.drop), 32'd0);
    force_busy = 1'b0;
    cyc();
    chk("ovw_start", 32'(bus.tx_start), 32'd1);
    chk("ovw_data", 32'(bus.tx_data), 32'h42);
    chk("ovw_grant", 32'(bus.grant), 32'b100);
    cyc(25);
    chk("ovw_pend0", 32'(bus.pending), 32'd0);

    // set-wins collision on channel 1
    force_busy = 1'b1;
    pulse_req(3'b010, 8'h00, 8'h30, 8'h00);
    cyc();
    bus.req = 3'b000;
    cyc(2);
    force_busy = 1'b0;
    pulse_req(3'b010, 8'h00, 8'h31, 8'h00);
    cyc();
    bus.req = 3'b000;
    chk("coll_start", 32'(bus.tx_start), 32'd1);
    chk("coll_data", 32'(bus.tx_data), 32'h30);
    chk("coll_pend", 32'(bus.pending), 32'b010);
    chk("coll_drop", 32'(bus.drop), 32'd0);
    next_issue("coll_next", 8'h31, 3'b010);
    cyc(25);
    chk("coll_pend0", 32'(bus.pending), 32'd0);

    // timeout: model silent
    model_en = 1'b0;
    pulse_req(3'b001, 8'h52, 8'h00, 8'h00);
    cyc();
    bus.req = 3'b000;
    cyc();
    chk("tmo_start", 32'(bus.tx_start), 32'd1);
    pulse_req(3'b100, 8'h00, 8'h00, 8'h58);
    cyc();
    bus.req = 3'b000;
    cyc(14);
    chk("tmo_early", 32'(bus.timeout), 32'd0);
    cyc();
    chk("tmo_pulse", 32'(bus.timeout), 32'd1);
    chk("tmo_nostart", 32'(bus.tx_start), 32'd0);
    cyc();
    chk("tmo_width", 32'(bus.timeout), 32'd0);
    chk("tmo_next_start", 32'(bus.tx_start), 32'd1);
    chk("tmo_next_data", 32'(bus.tx_data), 32'h58);
    chk("tmo_next_grant", 32'(bus.grant), 32'b100);
    cyc(20);
    model_en = 1'b1;

    // reset mid-frame with pending 101
    pulse_req(3'b010, 8'h00, 8'h31, 8'h00);
    cyc();
    bus.req = 3'b000;
    cyc();
    chk("rmf_start", 32'(bus.tx_start), 32'd1);
    pulse_req(3'b101, 8'h52, 8'h00, 8'h58);
    cyc();
    bus.req = 3'b000;
    cyc(4);
    chk("rmf_pend", 32'(bus.pending), 32'b101);
    reset = 1'b0;
    #1;
    chk("rmf_start0", 32'(bus.tx_start), 32'd0);
    chk("rmf_data0", 32'(bus.tx_data), 32'd0);
    chk("rmf_grant0", 32'(bus.grant), 32'd0);
    chk("rmf_pend0", 32'(bus.pending), 32'd0);
    chk("rmf_drop0", 32'(bus.drop), 32'd0);
    chk("rmf_tmo0", 32'(bus.timeout), 32'd0);
    cyc(2);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (bus.tx_start) seen = 1'b1;
    end
    chk("rmf_quiet", 32'(seen), 32'd0);
    chk("rmf_pend_after", 32'(bus.pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
